// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, waits a settle period,
// then counts synchronized rising edges of the tap over a gate window of clk cycles.
module ring_freq_meter #(
  parameter int GATE_W        = 16,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              ro_in,
  output logic              ro_en,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ack,
  output logic              overflow,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_ONE     = SET_W'(1);
  localparam logic [GATE_W-1:0] GATE_ONE    = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

  state_t            state_q;
  logic              sync1_q, sync2_q, prev_q;
  logic [SET_W-1:0]  settle_q;
  logic [GATE_W-1:0] glen_q;
  logic [GATE_W-1:0] gate_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sat_q;
  logic              ro_en_q, busy_q;
  logic [CNT_W-1:0]  result_q;
  logic              result_valid_q, overflow_q, overrun_q;

  logic              rise;
  logic [CNT_W-1:0]  cnt_d;
  logic              sat_d;

  // Count including this cycle's rise; the saturation flag marks a lost edge.
  always_comb begin
    rise  = sync2_q & ~prev_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (rise) begin
      if (cnt_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Result handshake: result_valid stays high until a cycle with result_ack=1;
  // a window completing in that same cycle wins and keeps result_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      settle_q       <= '0;
      glen_q         <= '0;
      gate_q         <= '0;
      cnt_q          <= '0;
      sat_q          <= 1'b0;
      ro_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sync1_q <= ro_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;

      if (result_ack && result_valid_q) begin
        result_valid_q <= 1'b0;
        overrun_q      <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            glen_q   <= (gate_len == '0) ? GATE_ONE : gate_len;
            settle_q <= SETTLE_INIT;
            ro_en_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (settle_q == '0) begin
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            gate_q  <= glen_q - GATE_ONE;
            state_q <= ST_COUNT;
          end else begin
            settle_q <= settle_q - SET_ONE;
          end
        end
        ST_COUNT: begin
          if (gate_q == '0) begin
            result_q       <= cnt_d;
            overflow_q     <= sat_d;
            result_valid_q <= 1'b1;
            if (result_valid_q && !result_ack) begin
              overrun_q <= 1'b1;
            end
            if (continuous) begin
              gate_q <= glen_q - GATE_ONE;
              cnt_q  <= '0;
              sat_q  <= 1'b0;
            end else begin
              ro_en_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            gate_q <= gate_q - GATE_ONE;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
          end
        end
        default: begin
          ro_en_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ro_en        = ro_en_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;
  assign overrun      = overrun_q;
  assign dbg_state    = state_q;

endmodule
